text_buf_ctrl: RTL and testbench



---
 rtl/text_buf_ctrl_if.sv | 16 +
 rtl/text_buf_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_text_buf_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/text_buf_ctrl_if.sv
// Command handshake and character-buffer write port of text_buf_ctrl.
interface text_buf_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [7:0]  cmd_char;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;

    // master: keyboard/command side; slave: the buffer controller
    modport master (output cmd_valid, cmd_type, cmd_char,
                    input  cmd_ready, wr_en, wr_addr, wr_data);
    modport slave  (input  cmd_valid, cmd_type, cmd_char,
                    output cmd_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/text_buf_ctrl.sv
// Write-side controller of the 64x30 text buffer: commands -> buffer writes, cursor and
// line tracking, scrolling via a circular top-row pointer. Prompt feature: TBC_PROMPT_EN.
module text_buf_ctrl #(
    parameter int         COLS  = 64,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h00
`ifdef TBC_PROMPT_EN
    , parameter logic [7:0] PROMPT = 8'h24
`endif
) (
    input  logic           clk,
    input  logic           rst,
    text_buf_ctrl_if.slave bus,
    output logic [5:0]     cur_x,
    output logic [4:0]     cur_y,
    output logic [4:0]     top_row,
    output logic           busy
);
    localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam logic [10:0] LAST_ADDR = {LAST_ROW, LAST_COL};

    typedef enum logic [2:0] {
        INIT_CLR, IDLE, HOLD, NEWLINE, CLR_ROW
`ifdef TBC_PROMPT_EN
        , PROMPT_WR
`endif
    } state_t;

    state_t      state_reg, state_next, after_nl;
    logic [10:0] cnt_reg, cnt_next;
    logic [4:0]  lrow_reg, lrow_next;
    logic [5:0]  cur_x_reg, cur_x_next;
    logic [4:0]  top_row_reg, top_row_next;
    logic        wr_en_reg, wr_en_next;
    logic [10:0] wr_addr_reg, wr_addr_next;
    logic [7:0]  wr_data_reg, wr_data_next;

    logic [5:0]  line_len_reg [ROWS];
    logic        ll_we, ll_clr;
    logic [4:0]  ll_idx;
    logic [5:0]  ll_val;

    logic [5:0]  row_sum;
    logic [4:0]  phys, prev_phys;
    logic [5:0]  min_x;
    logic        ready;

`ifdef TBC_PROMPT_EN
    logic        pflag_reg [ROWS];
    logic        pf_we;
    logic [4:0]  pf_idx;
    logic        pf_val;
    logic        need_prompt_reg, need_prompt_next;
    logic [4:0]  next_phys;

    assign next_phys = (phys == LAST_ROW) ? 5'd0 : phys + 5'd1;
    assign min_x     = {5'd0, pflag_reg[phys]};
    assign after_nl  = need_prompt_reg ? PROMPT_WR : IDLE;
`else
    assign min_x     = 6'd0;
    assign after_nl  = IDLE;
`endif

    // Logical row -> physical row, wrapping modulo ROWS without a divider
    assign row_sum   = {1'b0, top_row_reg} + {1'b0, lrow_reg};
    assign phys      = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
    assign prev_phys = (phys == 5'd0) ? LAST_ROW : phys - 5'd1;

    assign ready         = (state_reg == IDLE);
    assign bus.cmd_ready = ready;
    assign busy          = ~ready;
    assign bus.wr_en     = wr_en_reg;
    assign bus.wr_addr   = wr_addr_reg;
    assign bus.wr_data   = wr_data_reg;
    assign cur_x         = cur_x_reg;
    assign cur_y         = phys;
    assign top_row       = top_row_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        lrow_next    = lrow_reg;
        cur_x_next   = cur_x_reg;
        top_row_next = top_row_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        ll_we        = 1'b0;
        ll_clr       = 1'b0;
        ll_idx       = phys;
        ll_val       = cur_x_reg;
`ifdef TBC_PROMPT_EN
        pf_we            = 1'b0;
        pf_idx           = phys;
        pf_val           = 1'b0;
        need_prompt_next = need_prompt_reg;
`endif
        case (state_reg)
            INIT_CLR: begin
                // COLS is a power of two, so the linear count is already {row, col}
                wr_en_next   = 1'b1;
                wr_addr_next = cnt_reg;
                wr_data_next = BLANK;
                if (cnt_reg == LAST_ADDR) begin
                    cnt_next     = '0;
                    top_row_next = '0;
                    lrow_next    = '0;
                    cur_x_next   = '0;
                    ll_clr       = 1'b1;
`ifdef TBC_PROMPT_EN
                    state_next   = PROMPT_WR;
`else
                    state_next   = IDLE;
`endif
                end else begin
                    cnt_next = cnt_reg + 11'd1;
                end
            end
            IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_type)
                        2'd0: begin
                            wr_en_next   = 1'b1;
                            wr_addr_next = {phys, cur_x_reg};
                            wr_data_next = bus.cmd_char;
                            cur_x_next   = cur_x_reg + 6'd1;
                            state_next   = HOLD;
                            if (cur_x_reg == LAST_COL) begin
                                ll_we      = 1'b1;
                                ll_val     = LAST_COL;
                                state_next = NEWLINE;
`ifdef TBC_PROMPT_EN
                                need_prompt_next = 1'b0;
`endif
                            end
                        end
                        2'd1: begin
                            state_next = IDLE;
                            if (cur_x_reg > min_x) begin
                                cur_x_next   = cur_x_reg - 6'd1;
                                wr_en_next   = 1'b1;
                                wr_addr_next = {phys, cur_x_reg - 6'd1};
                                wr_data_next = BLANK;
                                state_next   = HOLD;
                            end else if (lrow_reg != 5'd0) begin
                                lrow_next  = lrow_reg - 5'd1;
                                cur_x_next = line_len_reg[prev_phys];
                            end
                        end
                        2'd2: begin
                            ll_we      = 1'b1;
                            state_next = NEWLINE;
`ifdef TBC_PROMPT_EN
                            need_prompt_next = 1'b1;
`endif
                        end
                        default: begin
                            cnt_next   = '0;
                            state_next = INIT_CLR;
                        end
                    endcase
                end
            end
            HOLD: state_next = IDLE;
            NEWLINE: begin
                cur_x_next = '0;
                if (lrow_reg != LAST_ROW) begin
                    lrow_next  = lrow_reg + 5'd1;
                    state_next = after_nl;
`ifdef TBC_PROMPT_EN
                    pf_we  = 1'b1;
                    pf_idx = next_phys;
`endif
                end else begin
                    // Advancing top_row makes the oldest row the new bottom row
                    top_row_next = (top_row_reg == LAST_ROW) ? 5'd0 : top_row_reg + 5'd1;
                    cnt_next     = '0;
                    state_next   = CLR_ROW;
                end
            end
            CLR_ROW: begin
                wr_en_next   = 1'b1;
                wr_addr_next = {phys, cnt_reg[5:0]};
                wr_data_next = BLANK;
                if (cnt_reg[5:0] == LAST_COL) begin
                    cnt_next   = '0;
                    ll_we      = 1'b1;
                    ll_val     = 6'd0;
                    state_next = after_nl;
`ifdef TBC_PROMPT_EN
                    pf_we = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg + 11'd1;
                end
            end
`ifdef TBC_PROMPT_EN
            PROMPT_WR: begin
                wr_en_next   = 1'b1;
                wr_addr_next = {phys, 6'd0};
                wr_data_next = PROMPT;
                pf_we        = 1'b1;
                pf_val       = 1'b1;
                cur_x_next   = 6'd1;
                state_next   = IDLE;
            end
`endif
            default: begin
                cnt_next   = '0;
                state_next = INIT_CLR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= INIT_CLR;
            cnt_reg     <= '0;
            lrow_reg    <= '0;
            cur_x_reg   <= '0;
            top_row_reg <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            lrow_reg    <= lrow_next;
            cur_x_reg   <= cur_x_next;
            top_row_reg <= top_row_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) line_len_reg[i] <= '0;
        end else if (ll_clr) begin
            for (int i = 0; i < ROWS; i++) line_len_reg[i] <= '0;
        end else if (ll_we) begin
            line_len_reg[ll_idx] <= ll_val;
        end
    end

`ifdef TBC_PROMPT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            need_prompt_reg <= 1'b0;
            for (int i = 0; i < ROWS; i++) pflag_reg[i] <= 1'b0;
        end else begin
            need_prompt_reg <= need_prompt_next;
            if (ll_clr) begin
                for (int i = 0; i < ROWS; i++) pflag_reg[i] <= 1'b0;
            end else if (pf_we) begin
                pflag_reg[pf_idx] <= pf_val;
            end
        end
    end
`endif
endmodule

// File: tb/tb_text_buf_ctrl.sv
// Randomized self-checking bench for text_buf_ctrl against a command-level screen model.
module tb_text_buf_ctrl;
    localparam int         ROWS   = 30;
    localparam int         COLS   = 64;
    localparam logic [7:0] BLANK  = 8'h00;
    localparam logic [7:0] PROMPT = 8'h24;
`ifdef TBC_PROMPT_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] cur_x;
    logic [4:0] cur_y;
    logic [4:0] top_row;
    logic       busy;

    text_buf_ctrl_if bus();

    text_buf_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .top_row (top_row),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Command-level model: screen cursor, scroll pointer, per-row length and prompt flag
    int m_top, m_lrow, m_cx;
    int m_len [ROWS];
    bit m_pf  [ROWS];
    int exp_q [$];
    int got_q [$];

    function automatic int mphys(input int l);
        return (m_top + l) % ROWS;
    endfunction

    task automatic m_push(input int row, input int col, input logic [7:0] d);
        exp_q.push_back((row * COLS + col) * 256 + int'(d));
    endtask

    task automatic m_init();
        for (int a = 0; a < ROWS * COLS; a++) exp_q.push_back(a * 256 + int'(BLANK));
        m_top = 0; m_lrow = 0; m_cx = 0;
        for (int r = 0; r < ROWS; r++) begin m_len[r] = 0; m_pf[r] = 1'b0; end
        if (PEN) begin m_push(0, 0, PROMPT); m_pf[0] = 1'b1; m_cx = 1; end
    endtask

    task automatic m_newline(input bit pr);
        int p;
        m_cx = 0;
        if (m_lrow < ROWS - 1) begin
            m_lrow++;
            m_pf[mphys(m_lrow)] = 1'b0;
        end else begin
            m_top = (m_top + 1) % ROWS;
            p = mphys(m_lrow);
            for (int col = 0; col < COLS; col++) m_push(p, col, BLANK);
            m_len[p] = 0;
            m_pf[p]  = 1'b0;
        end
        if (pr && PEN) begin
            p = mphys(m_lrow);
            m_push(p, 0, PROMPT);
            m_pf[p] = 1'b1;
            m_cx = 1;
        end
    endtask

    task automatic m_cmd(input logic [1:0] t, input logic [7:0] c);
        int p;
        p = mphys(m_lrow);
        case (t)
            2'd0: begin
                m_push(p, m_cx, c);
                if (m_cx == COLS - 1) begin m_len[p] = COLS - 1; m_newline(1'b0); end
                else m_cx++;
            end
            2'd1: begin
                if (m_cx > int'(m_pf[p])) begin
                    m_cx--;
                    m_push(p, m_cx, BLANK);
                end else if (m_lrow > 0) begin
                    m_lrow--;
                    m_cx = m_len[mphys(m_lrow)];
                end
            end
            2'd2: begin m_len[p] = m_cx; m_newline(1'b1); end
            default: m_init();
        endcase
    endtask

    // Gather writes until the controller is ready again; k counts falling edges after accept
    task automatic collect(output int k, output int first);
        k = 0; first = 0;
        got_q.delete();
        do begin
            @(negedge clk);
            k++;
            if (bus.wr_en) begin
                got_q.push_back(int'({bus.wr_addr, bus.wr_data}));
                if (first == 0) first = k;
            end
        end while (!bus.cmd_ready && k < 2500);
        check("ready_return", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic compare_all();
        check("write_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("write_addr_data", 32'(got_q[i]), 32'(exp_q[i]));
            if (got_q[i] != exp_q[i]) break;
        end
        check("cur_x", 32'(cur_x), 32'(m_cx));
        check("cur_y", 32'(cur_y), 32'(mphys(m_lrow)));
        check("top_row", 32'(top_row), 32'(m_top));
    endtask

    task automatic send(input logic [1:0] t, input logic [7:0] c);
        int k, first;
        bus.cmd_type  = t;
        bus.cmd_char  = c;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        exp_q.delete();
        m_cmd(t, c);
        collect(k, first);
        compare_all();
        if ((t == 2'd0 || t == 2'd1) && exp_q.size() == 1) begin
            check("write_latency", 32'(first), 32'd1);
            check("ready_gap", 32'(k), 32'd2);
        end else if (t == 2'd1) begin
            check("ready_gap_nowrite", 32'(k), 32'd1);
        end
        $display("cmd type=%0d char=%02h writes=%0d cursor=(%0d,%0d) top=%0d",
                 t, c, got_q.size(), cur_x, cur_y, top_row);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, first, r;
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'd0;
        bus.cmd_char  = 8'h00;
        #2;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_cur_x", 32'(cur_x), 32'd0);
        check("rst_cur_y", 32'(cur_y), 32'd0);
        check("rst_top_row", 32'(top_row), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_init();
        collect(k, first);
        compare_all();
        check("init_cycles", 32'(k), PEN ? 32'd1921 : 32'd1920);
        $display("init writes=%0d cursor=(%0d,%0d)", got_q.size(), cur_x, cur_y);

        send(2'd0, 8'h41);
        for (int i = 0; i < COLS && m_lrow == 0; i++) send(2'd0, 8'($urandom_range(32, 126)));
        send(2'd1, 8'h00);
        for (int i = 0; i < COLS + 2 && m_cx > int'(m_pf[mphys(m_lrow)]); i++) send(2'd1, 8'h00);
        send(2'd1, 8'h00);
        for (int i = 0; i < ROWS; i++) send(2'd2, 8'h00);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      send(2'd0, 8'($urandom_range(32, 126)));
            else if (r < 80) send(2'd1, 8'h00);
            else if (r < 99) send(2'd2, 8'h00);
            else             send(2'd3, 8'h00);
        end

        // Bring the cursor to the bottom row, then reset in the middle of a scroll
        for (int i = 0; i < ROWS && m_lrow != ROWS - 1; i++) send(2'd2, 8'h00);
        bus.cmd_type  = 2'd2;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("clr_row_writing", 32'(bus.wr_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("async_rst_top_row", 32'(top_row), 32'd0);
        check("async_rst_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_init();
        collect(k, first);
        compare_all();
        $display("reinit writes=%0d cursor=(%0d,%0d) top=%0d", got_q.size(), cur_x, cur_y, top_row);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
